// File: rtl/countdown_timer.sv
// Min:sec countdown timer with preset load, start/stop control and expiry flag.
// One decrement per TICK_DIV clocks while running; alarm pulses once on reaching 00:00.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;

  logic          tick_s;
  logic          nonzero_s;
  logic [5:0]    dec_min_s;
  logic [5:0]    dec_sec_s;

  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  assign tick_s    = (state_q == RUN) && (presc_q == TICK_LAST);
  assign nonzero_s = (min_q != 6'd0) || (sec_q != 6'd0);

  // Borrow from minutes when seconds are exhausted; min never goes below zero.
  always_comb begin
    dec_min_s = min_q;
    dec_sec_s = sec_q;
    if (sec_q != 6'd0) begin
      dec_sec_s = sec_q - 6'd1;
    end else if (min_q != 6'd0) begin
      dec_sec_s = 6'd59;
      dec_min_s = min_q - 6'd1;
    end else begin
      dec_sec_s = 6'd0;
    end
  end

  // Next-state logic: load > stop > start, then ticking while in RUN.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    presc_d   = presc_q;
    running_d = running_q;
    done_d    = done_q;
    alarm_d   = 1'b0;

    if (load) begin
      state_d   = IDLE;
      min_d     = clamp59(load_min);
      sec_d     = clamp59(load_sec);
      presc_d   = '0;
      running_d = 1'b0;
      done_d    = 1'b0;
    end else if (stop) begin
      // A tick landing on the same edge as stop is dropped.
      if (state_q == RUN) begin
        state_d   = PAUSE;
        presc_d   = '0;
        running_d = 1'b0;
      end else begin
        state_d = state_q;
      end
    end else if (start && ((state_q == IDLE) || (state_q == PAUSE)) && nonzero_s) begin
      state_d   = RUN;
      presc_d   = '0;
      running_d = 1'b1;
    end else if (state_q == RUN) begin
      if (tick_s) begin
        presc_d = '0;
        min_d   = dec_min_s;
        sec_d   = dec_sec_s;
        if ((dec_min_s == 6'd0) && (dec_sec_s == 6'd0)) begin
          state_d   = EXPIRED;
          running_d = 1'b0;
          done_d    = 1'b1;
          alarm_d   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign min     = min_q;
  assign sec     = sec_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance with TICK_DIV=1, one with TICK_DIV=4.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       stop;

  logic [5:0] min1, sec1, min4, sec4;
  logic       running1, done1, alarm1, running4, done4, alarm4;

  int checks = 0;
  int errors = 0;
  int alarm_cnt;

  countdown_timer #(.TICK_DIV(1)) u1 (
    .clk(clk), .reset(reset), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .stop(stop), .min(min1), .sec(sec1),
    .running(running1), .done(done1), .alarm(alarm1)
  );

  countdown_timer #(.TICK_DIV(4)) u4 (
    .clk(clk), .reset(reset), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .stop(stop), .min(min4), .sec(sec4),
    .running(running4), .done(done4), .alarm(alarm4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; afterwards outputs reflect the sampling edge.
  task automatic cyc(input logic ld, input logic st, input logic sp);
    load  = ld;
    start = st;
    stop  = sp;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] m, input logic [5:0] s);
    load_min = m;
    load_sec = s;
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    load_min = 6'd0; load_sec = 6'd0;
    repeat (2) @(negedge clk);
    chk("rst_min", min1, 0);
    chk("rst_sec", sec1, 0);
    chk("rst_running", running1, 0);
    chk("rst_done", done1, 0);
    chk("rst_alarm", alarm1, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_sec", sec1, 0);

    // Basic countdown 00:05
    do_load(6'd0, 6'd5);
    chk("basic_load_sec", sec1, 5);
    chk("basic_load_run", running1, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("basic_start_run", running1, 1);
    chk("basic_start_sec", sec1, 5);
    for (int i = 4; i >= 0; i--) begin
      @(negedge clk);
      chk("basic_sec", sec1, i);
      chk("basic_alarm", alarm1, (i == 0) ? 1 : 0);
    end
    chk("basic_done", done1, 1);
    chk("basic_running", running1, 0);
    @(negedge clk);
    chk("basic_alarm_drop", alarm1, 0);
    chk("basic_done_hold", done1, 1);

    // start/stop ignored in EXPIRED
    cyc(1'b0, 1'b1, 1'b0);
    chk("exp_start_run", running1, 0);
    chk("exp_start_done", done1, 1);
    chk("exp_start_alarm", alarm1, 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("exp_stop_done", done1, 1);
    chk("exp_stop_sec", sec1, 0);

    // Reload after expiry
    do_load(6'd0, 6'd3);
    chk("reload_done", done1, 0);
    chk("reload_sec", sec1, 3);
    chk("reload_run", running1, 0);
    cyc(1'b0, 1'b1, 1'b0);
    alarm_cnt = 0;
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk);
      chk("reload_sec_cnt", sec1, i);
      if (alarm1 === 1'b1) alarm_cnt++;
    end
    @(negedge clk);
    if (alarm1 === 1'b1) alarm_cnt++;
    chk("reload_alarm_once", alarm_cnt, 1);
    chk("reload_done_set", done1, 1);

    // Borrow 02:00
    do_load(6'd2, 6'd0);
    cyc(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("borrow_min1", min1, 1);
    chk("borrow_sec1", sec1, 59);
    @(negedge clk);
    chk("borrow_min2", min1, 1);
    chk("borrow_sec2", sec1, 58);
    repeat (117) @(negedge clk);
    chk("borrow_119_min", min1, 0);
    chk("borrow_119_sec", sec1, 1);
    chk("borrow_119_done", done1, 0);
    @(negedge clk);
    chk("borrow_end_min", min1, 0);
    chk("borrow_end_sec", sec1, 0);
    chk("borrow_end_done", done1, 1);
    chk("borrow_end_alarm", alarm1, 1);

    // start+stop together in RUN pauses, tick on that edge dropped
    do_load(6'd0, 6'd10);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("prio_pre_sec", sec1, 8);
    cyc(1'b0, 1'b1, 1'b1);
    chk("prio_run", running1, 0);
    chk("prio_sec", sec1, 8);
    @(negedge clk);
    chk("prio_hold_sec", sec1, 8);

    // load beats start; clamp
    load_min = 6'd0; load_sec = 6'd7;
    cyc(1'b1, 1'b1, 1'b0);
    chk("load_over_start_run", running1, 0);
    chk("load_over_start_sec", sec1, 7);
    do_load(6'd63, 6'd63);
    chk("clamp_min", min1, 59);
    chk("clamp_sec", sec1, 59);
    do_load(6'd60, 6'd59);
    chk("clamp60_min", min1, 59);

    // start at 00:00 has no effect
    do_load(6'd0, 6'd0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("zero_start_run", running1, 0);
    @(negedge clk);
    chk("zero_start_alarm", alarm1, 0);
    chk("zero_start_done", done1, 0);

    // Asynchronous reset mid-RUN
    do_load(6'd1, 6'd30);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("arst_pre_sec", sec1, 27);
    #2 reset = 1'b0;
    #1;
    chk("arst_min", min1, 0);
    chk("arst_sec", sec1, 0);
    chk("arst_running", running1, 0);
    chk("arst_done", done1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cyc(1'b0, 1'b1, 1'b0);
    chk("arst_zero_start_run", running1, 0);
    chk("arst_zero_start_sec", sec1, 0);

    // Pause/resume with TICK_DIV=4
    do_load(6'd0, 6'd10);
    cyc(1'b0, 1'b1, 1'b0);
    chk("p4_start_run", running4, 1);
    repeat (3) @(negedge clk);
    chk("p4_first_pending", sec4, 10);
    @(negedge clk);
    chk("p4_first_tick", sec4, 9);
    repeat (4) @(negedge clk);
    chk("p4_sec8", sec4, 8);
    cyc(1'b0, 1'b0, 1'b1);
    chk("p4_stop_run", running4, 0);
    chk("p4_stop_sec", sec4, 8);
    repeat (20) @(negedge clk);
    chk("p4_hold_sec", sec4, 8);
    chk("p4_hold_run", running4, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("p4_resume_run", running4, 1);
    repeat (3) @(negedge clk);
    chk("p4_resume_pending", sec4, 8);
    @(negedge clk);
    chk("p4_resume_tick", sec4, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Count-down companion to the up-counting stopwatch in the DDCO lab set. It loads a min:sec preset, decrements it once per tick while running, and flags expiry at 00:00. Its start/stop button semantics and 6-bit min/sec outputs match the stopwatch, so both blocks share the same display and button front-end.

## Interface
- TICK_DIV, default 1: clock cycles per one-second tick. 1 gives one decrement per clk in simulation. Legal range 1..2^24.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset. reset=0 forces the reset state immediately; release is sampled on clk.
- load  in  1  one-cycle pulse that captures load_min/load_sec.
- load_min  in  6  preset minutes, 0..59; values >59 clamp to 59.
- load_sec  in  6  preset seconds, 0..59; values >59 clamp to 59.
- start  in  1  pulse that begins or resumes counting.
- stop  in  1  pulse that pauses counting.
- min  out  6  current minutes.
- sec  out  6  current seconds.
- running  out  1  high while in RUN.
- done  out  1  level; high while in EXPIRED.
- alarm  out  1  one-cycle pulse on entry to EXPIRED.

## Operation
- **States:** IDLE, RUN, PAUSE, EXPIRED. Reset state is IDLE with min=0, sec=0, running=0, done=0, alarm=0, prescaler=0.
- **Input priority** within a cycle: load > stop > start. Any asserted combination acts on the highest-priority input only.
- **load** in any state:
  - min/sec take the clamped preset.
  - Prescaler clears; state goes to IDLE.
  - done clears; alarm stays 0.
- **start:**
  - In IDLE or PAUSE with (min,sec)≠(0,0): go to RUN and clear the prescaler.
  - In IDLE or PAUSE with 00:00: no effect.
  - In RUN or EXPIRED: no effect.
- **stop:**
  - In RUN: go to PAUSE; min/sec hold; prescaler clears.
  - In any other state: no effect.
- **Tick:** in RUN the prescaler counts 0..TICK_DIV-1. A tick fires on the cycle it equals TICK_DIV-1, and the prescaler wraps to 0.
- **Decrement** on a tick:
  - sec>0: sec-1.
  - sec=0 and min>0: sec=59, min-1 (borrow).
  - If the result is 00:00: go to EXPIRED in the same edge, assert alarm for exactly that next cycle, done=1, running=0.
- **EXPIRED:** min/sec hold at 00:00; done stays high until load or reset. start and stop are ignored.
- **Arithmetic:** unsigned 6-bit. min never wraps below 0, and 59→0 upward wrap never occurs.
- **Reset mid-operation:** all outputs go to their reset values immediately (asynchronous). A pending tick or alarm is lost.

## Timing
- Outputs are registered; nothing is combinational from inputs to outputs.
- start sampled at edge N gives running=1 after edge N.
- The first decrement is visible after edge N+TICK_DIV; subsequent decrements follow every TICK_DIV edges.
- stop sampled at edge M gives running=0 after edge M. A tick coinciding with edge M is not applied (stop wins).
- load sampled at edge L gives the new min/sec after edge L.
- Expiry: the edge that produces 00:00 also sets done=1 and alarm=1. alarm returns to 0 after the following edge.
- Resume from PAUSE restarts a full TICK_DIV interval, so partial-second progress is discarded.

## Test plan
- **Basic countdown:** TICK_DIV=1, load 00:05, start → sec reads 4,3,2,1,0 on five consecutive edges. alarm is high exactly one cycle coincident with sec=0; done=1; running=0.
- **Borrow:** load 02:00, start, TICK_DIV=1 → 01:59 after the first tick, then 01:58. Run 120 ticks total → 00:00 with done=1.
- **Pause/resume:** TICK_DIV=4, load 00:10, start, stop after 9 cycles → sec=8 and holds for 20 cycles. start → sec=7 exactly 4 cycles later.
- **Priority/boundaries:**
  - start and stop asserted together in RUN → PAUSE.
  - load 63:63 → 59:59.
  - start at 00:00 → running stays 0, alarm never asserts.
  - start/stop in EXPIRED → no change.
- **Async reset:** assert reset=0 mid-RUN between clock edges → min=0, sec=0, running=0, done=0 before the next edge. After release, start with 00:00 has no effect.
- **Reload after expiry:** after done=1, load 00:03 → done=0, state IDLE. start → counts 2,1,0 and alarm pulses again once.
